// File: rtl/orbit_pos_gen.sv
// orbit_pos_gen: turns keyboard rotation commands into a shared angle index
// and, once per frame tick, computes the red/blue ball centres on a circle
// using a sequential cosine-table lookup and one multiply per coordinate.
module orbit_pos_gen #(
  parameter int         X_CENTER = 320,
  parameter int         Y_CENTER = 240,
  parameter int         RADIUS   = 80,
  parameter int         REPEAT   = 4,
  parameter logic [7:0] KEY_CW   = 8'd7,
  parameter logic [7:0] KEY_CCW  = 8'd4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [5:0] Index,
  output logic [9:0] RedX,
  output logic [9:0] RedY,
  output logic [9:0] BlueX,
  output logic [9:0] BlueY,
  output logic       pos_valid,
  output logic       busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RX   = 3'd1;
  localparam logic [2:0] S_RY   = 3'd2;
  localparam logic [2:0] S_BX   = 3'd3;
  localparam logic [2:0] S_BY   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_CW   = 2'd1;
  localparam logic [1:0] DIR_CCW  = 2'd2;

  localparam logic [7:0] RADIUS_C     = 8'(RADIUS);
  localparam logic [9:0] X_CENTER_C   = 10'(X_CENTER);
  localparam logic [9:0] Y_CENTER_C   = 10'(Y_CENTER);
  localparam logic [9:0] RED_X_RST_C  = 10'(X_CENTER + RADIUS);
  localparam logic [9:0] BLUE_X_RST_C = 10'(X_CENTER - RADIUS);
  localparam logic [3:0] RPT_RELOAD_C = 4'(REPEAT - 1);

  // (a + b) mod 60 for indices already in 0..59
  function automatic logic [5:0] add_mod60(input logic [5:0] a, input logic [5:0] b);
    logic [6:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 7'd60) begin
      s = s - 7'd60;
    end else begin
      s = s;
    end
    return s[5:0];
  endfunction

  // round(256*cos(6 deg * q)) for the first quarter wave, q = 0..15
  function automatic logic [8:0] cos_quarter(input logic [5:0] q);
    logic [8:0] m;
    case (q)
      6'd0:    m = 9'd256;
      6'd1:    m = 9'd255;
      6'd2:    m = 9'd250;
      6'd3:    m = 9'd243;
      6'd4:    m = 9'd234;
      6'd5:    m = 9'd222;
      6'd6:    m = 9'd207;
      6'd7:    m = 9'd190;
      6'd8:    m = 9'd171;
      6'd9:    m = 9'd150;
      6'd10:   m = 9'd128;
      6'd11:   m = 9'd104;
      6'd12:   m = 9'd79;
      6'd13:   m = 9'd53;
      6'd14:   m = 9'd27;
      default: m = 9'd0;
    endcase
    return m;
  endfunction

  // Full 60-entry cosine table, folded onto the quarter wave by symmetry
  function automatic logic signed [9:0] cos_lut(input logic [5:0] idx);
    logic [5:0] q;
    logic       neg;
    logic [9:0] mag;
    if (idx <= 6'd15) begin
      q = idx;          neg = 1'b0;
    end else if (idx <= 6'd30) begin
      q = 6'd30 - idx;  neg = 1'b1;
    end else if (idx <= 6'd45) begin
      q = idx - 6'd30;  neg = 1'b1;
    end else begin
      q = 6'd60 - idx;  neg = 1'b0;
    end
    mag = {1'b0, cos_quarter(q)};
    return neg ? (10'd0 - mag) : mag;
  endfunction

  logic [2:0] state_r;
  logic [2:0] state_nxt_s;
  logic       frame_prev_r;
  logic       tick_s;
  logic       start_s;
  logic       pending_r;
  logic [7:0] pend_key_r;
  logic [7:0] key_s;
  logic [1:0] dir_s;
  logic [1:0] last_dir_r;
  logic [3:0] rpt_cnt_r;
  logic [3:0] rpt_nxt_s;
  logic       step_s;
  logic [5:0] index_r;
  logic [5:0] index_nxt_s;
  logic [5:0] angle_s;
  logic signed [9:0] cos_s;
  logic [18:0] cos_ext_s;
  logic [18:0] rad_ext_s;
  logic [18:0] prod_s;
  logic [18:0] sum_s;
  logic [9:0]  off_s;
  logic [9:0]  coord_s;
  logic [9:0]  red_x_r, red_y_r, blue_x_r, blue_y_r;
  logic        pos_valid_r, busy_r;

  assign tick_s = frame_clk & ~frame_prev_r;
  // A queued tick is replayed straight out of DONE with the key captured when it arrived
  assign start_s = ((state_r == S_IDLE) && tick_s) ||
                   ((state_r == S_DONE) && (pending_r || tick_s));
  assign key_s = ((state_r == S_DONE) && pending_r) ? pend_key_r : keycode;

  // Next FSM state
  always_comb begin
    state_nxt_s = S_IDLE;
    case (state_r)
      S_IDLE:  state_nxt_s = tick_s ? S_RX : S_IDLE;
      S_RX:    state_nxt_s = S_RY;
      S_RY:    state_nxt_s = S_BX;
      S_BX:    state_nxt_s = S_BY;
      S_BY:    state_nxt_s = S_DONE;
      S_DONE:  state_nxt_s = (pending_r || tick_s) ? S_RX : S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Key decode, auto-repeat decision and next index
  always_comb begin
    dir_s       = DIR_NONE;
    step_s      = 1'b0;
    rpt_nxt_s   = rpt_cnt_r;
    index_nxt_s = index_r;
    if (key_s == KEY_CW) begin
      dir_s = DIR_CW;
    end else if (key_s == KEY_CCW) begin
      dir_s = DIR_CCW;
    end else begin
      dir_s = DIR_NONE;
    end
    if (dir_s == DIR_NONE) begin
      rpt_nxt_s = 4'd0;
    end else if (dir_s != last_dir_r) begin
      step_s    = 1'b1;
      rpt_nxt_s = RPT_RELOAD_C;
    end else if (rpt_cnt_r == 4'd0) begin
      step_s    = 1'b1;
      rpt_nxt_s = RPT_RELOAD_C;
    end else begin
      rpt_nxt_s = rpt_cnt_r - 4'd1;
    end
    if (step_s && (dir_s == DIR_CW)) begin
      index_nxt_s = (index_r == 6'd59) ? 6'd0 : index_r + 6'd1;
    end else if (step_s) begin
      index_nxt_s = (index_r == 6'd0) ? 6'd59 : index_r - 6'd1;
    end else begin
      index_nxt_s = index_r;
    end
  end

  // Table index per state: sin(i) = cos(i+45), blue = red + 30
  always_comb begin
    angle_s = index_r;
    case (state_r)
      S_RX:    angle_s = index_r;
      S_RY:    angle_s = add_mod60(index_r, 6'd45);
      S_BX:    angle_s = add_mod60(index_r, 6'd30);
      S_BY:    angle_s = add_mod60(index_r, 6'd15);
      default: angle_s = index_r;
    endcase
  end

  // Offset = round(COS*RADIUS/256); operands pre-extended so the low product bits are exact
  always_comb begin
    cos_s     = cos_lut(angle_s);
    cos_ext_s = {{9{cos_s[9]}}, cos_s};
    rad_ext_s = {11'd0, RADIUS_C};
    prod_s    = cos_ext_s * rad_ext_s;
    sum_s     = prod_s + 19'd128;
    off_s     = 10'($signed(sum_s) >>> 8);
    if ((state_r == S_RX) || (state_r == S_BX)) begin
      coord_s = X_CENTER_C + off_s;
    end else begin
      coord_s = Y_CENTER_C - off_s;
    end
  end

  // State, key tracking, pending tick and coordinate registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r      <= S_IDLE;
      frame_prev_r <= 1'b0;
      pending_r    <= 1'b0;
      pend_key_r   <= 8'd0;
      last_dir_r   <= DIR_NONE;
      rpt_cnt_r    <= 4'd0;
      index_r      <= 6'd0;
      red_x_r      <= RED_X_RST_C;
      red_y_r      <= Y_CENTER_C;
      blue_x_r     <= BLUE_X_RST_C;
      blue_y_r     <= Y_CENTER_C;
      pos_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      frame_prev_r <= frame_clk;
      pos_valid_r  <= (state_nxt_s == S_DONE);
      busy_r       <= (state_nxt_s != S_IDLE);
      if (start_s) begin
        pending_r  <= 1'b0;
        last_dir_r <= dir_s;
        rpt_cnt_r  <= rpt_nxt_s;
        index_r    <= index_nxt_s;
      end else if (tick_s && (state_r != S_IDLE) && !pending_r) begin
        pending_r  <= 1'b1;
        pend_key_r <= keycode;
      end else begin
        pending_r  <= pending_r;
      end
      case (state_r)
        S_RX:    red_x_r  <= coord_s;
        S_RY:    red_y_r  <= coord_s;
        S_BX:    blue_x_r <= coord_s;
        S_BY:    blue_y_r <= coord_s;
        default: red_x_r  <= red_x_r;
      endcase
    end
  end

  assign Index     = index_r;
  assign RedX      = red_x_r;
  assign RedY      = red_y_r;
  assign BlueX     = blue_x_r;
  assign BlueY     = blue_y_r;
  assign pos_valid = pos_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_orbit_pos_gen.sv
// Directed bench for orbit_pos_gen with hand-computed ball positions.
module tb_orbit_pos_gen;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [5:0] Index;
  logic [9:0] RedX, RedY, BlueX, BlueY;
  logic       pos_valid, busy;

  int total = 0;
  int bad   = 0;

  orbit_pos_gen dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .Index(Index), .RedX(RedX), .RedY(RedY), .BlueX(BlueX), .BlueY(BlueY),
    .pos_valid(pos_valid), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int idx, input int rx, input int ry,
                         input int bx, input int by);
    chk({tag, ".idx"}, int'(Index), idx);
    chk({tag, ".rx"},  int'(RedX),  rx);
    chk({tag, ".ry"},  int'(RedY),  ry);
    chk({tag, ".bx"},  int'(BlueX), bx);
    chk({tag, ".by"},  int'(BlueY), by);
  endtask

  // One tick with the given key; pos_valid expected 5 cycles after the tick edge
  task automatic do_tick(input logic [7:0] key, input string tag);
    int lat;
    lat = -1;
    keycode   = key;
    frame_clk = 1'b1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge Clk);
      frame_clk = 1'b0;
      if (pos_valid) lat = c;
    end
    chk({tag, ".lat"}, lat, 5);
    keycode = 8'd0;
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  int exp_idx [10] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3};
  int pulses, gap, seen_busy;

  initial begin
    Reset = 1'b0; frame_clk = 1'b0; keycode = 8'd0;
    repeat (3) @(negedge Clk);
    chk_pos("rst", 0, 400, 240, 240, 240);
    chk("rst.valid", int'(pos_valid), 0);
    chk("rst.busy",  int'(busy), 0);
    Reset = 1'b1;
    @(negedge Clk);

    // 1: no key
    do_tick(8'd0, "s1");
    chk_pos("s1", 0, 400, 240, 240, 240);

    // 2: one CW step
    do_tick(8'd7, "s2");
    chk_pos("s2", 1, 400, 232, 240, 248);

    // 3: CW held for 10 ticks, auto-repeat every 4
    do_reset();
    for (int t = 0; t < 10; t++) begin
      do_tick(8'd7, "s3");
      chk($sformatf("s3.idx%0d", t), int'(Index), exp_idx[t]);
    end

    // 4: CCW wrap, then CW steps
    do_reset();
    do_tick(8'd4, "s4a");
    chk_pos("s4a", 59, 400, 248, 240, 232);
    for (int t = 0; t < 10; t++) begin
      do_tick(8'd7, "s4s");
      do_tick(8'd0, "s4r");
    end
    chk("s4.idx9", int'(Index), 9);
    do_tick(8'd7, "s4b");
    chk_pos("s4b", 10, 360, 171, 280, 309);
    do_tick(8'd0, "s4c");

    // 5: three ticks two cycles apart, third one dropped
    pulses = 0; gap = 0; seen_busy = 0;
    for (int c = 0; c < 30; c++) begin
      frame_clk = (c < 6) && (c % 2 == 0);
      @(negedge Clk);
      if (pos_valid) pulses++;
      if (seen_busy != 0 && pulses < 2 && !busy) gap++;
      if (busy) seen_busy = 1;
    end
    chk("s5.pulses", pulses, 2);
    chk("s5.gap", gap, 0);
    chk("s5.idle", int'(busy), 0);

    // 6: reset during BX aborts the pass
    keycode = 8'd7; frame_clk = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clk);
      frame_clk = 1'b0;
    end
    chk("s6.bx_idx", int'(Index), 11);
    chk("s6.bx_rx", int'(RedX), 353);
    Reset = 1'b0;
    #1;
    chk_pos("s6.rst", 0, 400, 240, 240, 240);
    chk("s6.rst.busy", int'(busy), 0);
    chk("s6.rst.valid", int'(pos_valid), 0);
    keycode = 8'd0;
    @(negedge Clk);
    Reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if (pos_valid) pulses++;
    end
    chk("s6.novalid", pulses, 0);
    do_tick(8'd0, "s6b");
    chk_pos("s6b", 0, 400, 240, 240, 240);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
